quota_table_ctrl: RTL and testbench

//  Owns the per-ID charging table (6x CNT_W usage counters + quota/threshold flags) and shares it

---
 rtl/charging_pkg.sv | 53 +++++
 rtl/quota_debit.sv | 27 ++
 rtl/quota_table_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_quota_table_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charging_pkg.sv
// Shared types and constants for the charging table: policy codes, host field
// codes, counter-mask bit positions, FSM states and table power-up defaults.
package charging_pkg;

    typedef logic [2:0] policy_t;

    localparam policy_t POL_DROP = 3'd1;
    localparam policy_t POL_STH  = 3'd2;
    localparam policy_t POL_FWD  = 3'd4;

    // Host field codes; 0..5 follow the counter mask order
    localparam logic [2:0] FLD_QTOT  = 3'd0;
    localparam logic [2:0] FLD_QUL   = 3'd1;
    localparam logic [2:0] FLD_QDL   = 3'd2;
    localparam logic [2:0] FLD_TTOT  = 3'd3;
    localparam logic [2:0] FLD_TUL   = 3'd4;
    localparam logic [2:0] FLD_TDL   = 3'd5;
    localparam logic [2:0] FLD_QFLAG = 3'd6;
    localparam logic [2:0] FLD_TFLAG = 3'd7;

    // Counter index inside a table row == bit position in pkt_mask
    localparam int MSK_QTOT = 0;
    localparam int MSK_QUL  = 1;
    localparam int MSK_QDL  = 2;
    localparam int MSK_TTOT = 3;
    localparam int MSK_TUL  = 4;
    localparam int MSK_TDL  = 5;
    localparam int NUM_CNT  = 6;

    localparam longint unsigned INIT_QTOT = 64'd102400;
    localparam longint unsigned INIT_QUL  = 64'd71680;
    localparam longint unsigned INIT_QDL  = 64'd30720;
    localparam longint unsigned INIT_TTOT = 64'd81920;
    localparam longint unsigned INIT_TUL  = 64'd51200;
    localparam longint unsigned INIT_TDL  = 64'd30720;
    localparam logic [3:0]      INIT_QFLAG = 4'b0011;
    localparam logic [3:0]      INIT_TFLAG = 4'b1011;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // Default value loaded into counter k of every row during initialisation
    function automatic longint unsigned init_cnt(input int k);
        case (k)
            MSK_QTOT: return INIT_QTOT;
            MSK_QUL:  return INIT_QUL;
            MSK_QDL:  return INIT_QDL;
            MSK_TTOT: return INIT_TTOT;
            MSK_TUL:  return INIT_TUL;
            default:  return INIT_TDL;
        endcase
    endfunction

endpackage

// File: rtl/quota_debit.sv
// Single usage-counter debit: subtracts the packet length from a selected
// counter, clamping at zero and flagging the shortfall as an exceed.
module quota_debit #(
    parameter int CNT_W = 48
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] len,
    input  logic             sel,
    output logic [CNT_W-1:0] new_cnt,
    output logic             exceed
);

    // Clamp to zero on underflow; an exact hit on zero is not an exceed
    always_comb begin
        new_cnt = cnt;
        exceed  = 1'b0;
        if (sel) begin
            if (cnt < len) begin
                new_cnt = '0;
                exceed  = 1'b1;
            end else begin
                new_cnt = cnt - len;
            end
        end
    end

endmodule

// File: rtl/quota_table_ctrl.sv
// Charging table controller: initialises the per-ID table, arbitrates between
// packet debits and host config accesses (one per cycle, host starvation
// bounded), performs read/debit/write-back in one stage and registers the
// packet policy or host read data one cycle later.
// Optional build macro: QUOTA_STATS_EN adds 32-bit per-policy packet/byte
// statistics on the stats port; without it stats is tied to zero.
module quota_table_ctrl
    import charging_pkg::*;
#(
    parameter int NUM_IDS         = 4,
    parameter int ID_W            = 14,
    parameter int CNT_W           = 48,
    parameter int LEN_W           = 16,
    parameter int HOST_STARVE_MAX = 4
) (
    input  logic             asclk,
    input  logic             areset,
    input  logic             pkt_vld,
    output logic             pkt_rdy,
    input  logic [ID_W-1:0]  pkt_id,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             pkt_ul,
    input  logic             pkt_en,
    input  logic [5:0]       pkt_mask,
    input  logic             cfg_vld,
    output logic             cfg_rdy,
    input  logic             cfg_wr,
    input  logic [ID_W-1:0]  cfg_id,
    input  logic [2:0]       cfg_field,
    input  logic [CNT_W-1:0] cfg_wdata,
    output logic             cfg_rvld,
    output logic [CNT_W-1:0] cfg_rdata,
    output logic             res_vld,
    output logic [2:0]       res_policy,
    output logic [ID_W-1:0]  res_id,
    output logic             init_done,
    output logic [191:0]     stats
);

    localparam int IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
    localparam int SC_W  = (HOST_STARVE_MAX > 0) ? $clog2(HOST_STARVE_MAX + 1) : 1;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v == SC_W'(HOST_STARVE_MAX)) ? v : v + SC_W'(1);
    endfunction

    function automatic policy_t pol_min(input policy_t a, input policy_t b);
        return (a < b) ? a : b;
    endfunction

    // Uplink counters only debit uplink packets, downlink likewise; totals always
    function automatic logic dir_ok(input int k, input logic ul);
        case (k)
            MSK_QUL, MSK_TUL: return ul;
            MSK_QDL, MSK_TDL: return ~ul;
            default:          return 1'b1;
        endcase
    endfunction

    state_t           state;
    logic [IDX_W-1:0] init_idx;
    logic [SC_W-1:0]  starve_cnt;
    logic             starve, run, pkt_go, cfg_go;

    logic [CNT_W-1:0] cnt_tbl   [NUM_IDS][NUM_CNT];
    logic [3:0]       qflag_tbl [NUM_IDS];
    logic [3:0]       tflag_tbl [NUM_IDS];

    logic             vld_p1, is_cfg_p1, in_range_p1, wr_p1, ul_p1, en_p1;
    logic [ID_W-1:0]  id_p1;
    logic [LEN_W-1:0] len_p1;
    logic [5:0]       mask_p1;
    logic [2:0]       field_p1;
    logic [CNT_W-1:0] wdata_p1;

    logic [IDX_W-1:0] idx_p1;
    logic             pkt_upd_p1;
    logic [CNT_W-1:0] len_ext_p1;
    logic [CNT_W-1:0] cur_p1  [NUM_CNT];
    logic [CNT_W-1:0] next_p1 [NUM_CNT];
    logic [5:0]       sel_p1, exceed_p1;
    policy_t          quo_p1, thr_p1, pol_p1;
    logic [CNT_W-1:0] rd_p1;

    assign run     = (state == ST_RUN) & ~areset;
    assign starve  = (starve_cnt == SC_W'(HOST_STARVE_MAX));
    assign pkt_rdy = run & ~(cfg_vld & starve);
    assign cfg_rdy = run & (~pkt_vld | starve);
    assign pkt_go  = pkt_vld & pkt_rdy;
    assign cfg_go  = cfg_vld & cfg_rdy;

    // Control FSM: walk the table once after reset, then run arbitration bookkeeping
    always_ff @(posedge asclk) begin
        if (areset) begin
            state      <= ST_INIT;
            init_idx   <= '0;
            init_done  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_idx == IDX_W'(NUM_IDS - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_idx <= init_idx + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cfg_go || !cfg_vld) starve_cnt <= '0;
                    else if (pkt_go)        starve_cnt <= sat_inc(starve_cnt);
                end
            endcase
        end
    end

    // Stage p0 -> p1: valid of the granted access
    always_ff @(posedge asclk) begin
        if (areset) vld_p1 <= 1'b0;
        else        vld_p1 <= pkt_go | cfg_go;
    end

    // Stage p0 -> p1: request fields of whichever side was granted
    always_ff @(posedge asclk) begin
        if (pkt_go || cfg_go) begin
            is_cfg_p1   <= cfg_go;
            id_p1       <= cfg_go ? cfg_id : pkt_id;
            in_range_p1 <= (cfg_go ? cfg_id : pkt_id) < ID_W'(NUM_IDS);
            len_p1      <= pkt_len;
            ul_p1       <= pkt_ul;
            en_p1       <= pkt_en;
            mask_p1     <= pkt_mask;
            wr_p1       <= cfg_wr;
            field_p1    <= cfg_field;
            wdata_p1    <= cfg_wdata;
        end
    end

    assign idx_p1     = id_p1[IDX_W-1:0];
    assign len_ext_p1 = CNT_W'(len_p1);
    assign pkt_upd_p1 = vld_p1 & ~is_cfg_p1 & in_range_p1 & en_p1;

    // Stage p1: row read and per-counter selection
    always_comb begin
        for (int k = 0; k < NUM_CNT; k++) begin
            cur_p1[k] = cnt_tbl[idx_p1][k];
            sel_p1[k] = pkt_upd_p1 & mask_p1[k] & dir_ok(k, ul_p1);
        end
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_debit
        quota_debit #(.CNT_W(CNT_W)) u_debit (
            .cnt     (cur_p1[k]),
            .len     (len_ext_p1),
            .sel     (sel_p1[k]),
            .new_cnt (next_p1[k]),
            .exceed  (exceed_p1[k])
        );
    end

    // Stage p1: policy resolution and host read mux
    always_comb begin
        quo_p1 = POL_FWD;
        thr_p1 = POL_FWD;
        if (|exceed_p1[2:0]) quo_p1 = qflag_tbl[idx_p1][3] ? POL_STH : POL_DROP;
        if (|exceed_p1[5:3]) thr_p1 = tflag_tbl[idx_p1][3] ? POL_STH : POL_DROP;
        pol_p1 = pol_min(quo_p1, thr_p1);
        rd_p1 = '0;
        if (in_range_p1) begin
            case (field_p1)
                FLD_QFLAG: rd_p1 = CNT_W'(qflag_tbl[idx_p1]);
                FLD_TFLAG: rd_p1 = CNT_W'(tflag_tbl[idx_p1]);
                default:   rd_p1 = cur_p1[field_p1];
            endcase
        end
    end

    // Table storage: defaults during INIT, otherwise p1 write-back
    always_ff @(posedge asclk) begin
        if (state == ST_INIT) begin
            for (int k = 0; k < NUM_CNT; k++) cnt_tbl[init_idx][k] <= CNT_W'(init_cnt(k));
            qflag_tbl[init_idx] <= INIT_QFLAG;
            tflag_tbl[init_idx] <= INIT_TFLAG;
        end else if (!areset) begin
            if (pkt_upd_p1) begin
                for (int k = 0; k < NUM_CNT; k++) cnt_tbl[idx_p1][k] <= next_p1[k];
            end else if (vld_p1 && is_cfg_p1 && wr_p1 && in_range_p1) begin
                case (field_p1)
                    FLD_QFLAG: qflag_tbl[idx_p1] <= wdata_p1[3:0];
                    FLD_TFLAG: tflag_tbl[idx_p1] <= wdata_p1[3:0];
                    default:   cnt_tbl[idx_p1][field_p1] <= wdata_p1;
                endcase
            end
        end
    end

    // Stage p1 -> p2: registered packet result and host read response
    always_ff @(posedge asclk) begin
        if (areset) begin
            res_vld    <= 1'b0;
            res_policy <= '0;
            res_id     <= '0;
            cfg_rvld   <= 1'b0;
            cfg_rdata  <= '0;
        end else begin
            res_vld  <= vld_p1 & ~is_cfg_p1;
            cfg_rvld <= vld_p1 & is_cfg_p1 & ~wr_p1;
            if (vld_p1 && !is_cfg_p1) begin
                res_policy <= pol_p1;
                res_id     <= id_p1;
            end
            if (vld_p1 && is_cfg_p1 && !wr_p1) cfg_rdata <= rd_p1;
        end
    end

`ifdef QUOTA_STATS_EN
    logic [LEN_W-1:0] len_p2;
    logic [31:0]      fwd_bytes, sth_bytes, drop_bytes, fwd_cnt, sth_cnt, drop_cnt;

    // Stage p1 -> p2: length travels with the result for byte accounting
    always_ff @(posedge asclk) begin
        if (vld_p1 && !is_cfg_p1) len_p2 <= len_p1;
    end

    // Policy statistics, wrapping modulo 2^32
    always_ff @(posedge asclk) begin
        if (areset) begin
            fwd_bytes  <= '0;
            sth_bytes  <= '0;
            drop_bytes <= '0;
            fwd_cnt    <= '0;
            sth_cnt    <= '0;
            drop_cnt   <= '0;
        end else if (res_vld) begin
            case (res_policy)
                POL_DROP: begin
                    drop_cnt   <= drop_cnt + 32'd1;
                    drop_bytes <= drop_bytes + 32'(len_p2);
                end
                POL_STH: begin
                    sth_cnt   <= sth_cnt + 32'd1;
                    sth_bytes <= sth_bytes + 32'(len_p2);
                end
                default: begin
                    fwd_cnt   <= fwd_cnt + 32'd1;
                    fwd_bytes <= fwd_bytes + 32'(len_p2);
                end
            endcase
        end
    end

    assign stats = {fwd_bytes, sth_bytes, drop_bytes, fwd_cnt, sth_cnt, drop_cnt};
`else
    assign stats = '0;
`endif

endmodule

// File: tb/tb_quota_table_ctrl.sv
// Scenario bench for quota_table_ctrl: expected packet results and host read
// data are queued when a request handshakes and compared when the DUT responds.
`timescale 1ns/1ps
module tb_quota_table_ctrl;
    import charging_pkg::*;

    localparam int ID_W  = 14;
    localparam int CNT_W = 48;
    localparam int LEN_W = 16;

    logic             asclk = 1'b0;
    logic             areset = 1'b1;
    logic             pkt_vld = 1'b0, pkt_rdy;
    logic [ID_W-1:0]  pkt_id = '0;
    logic [LEN_W-1:0] pkt_len = '0;
    logic             pkt_ul = 1'b0, pkt_en = 1'b0;
    logic [5:0]       pkt_mask = '0;
    logic             cfg_vld = 1'b0, cfg_rdy, cfg_wr = 1'b0;
    logic [ID_W-1:0]  cfg_id = '0;
    logic [2:0]       cfg_field = '0;
    logic [CNT_W-1:0] cfg_wdata = '0;
    logic             cfg_rvld;
    logic [CNT_W-1:0] cfg_rdata;
    logic             res_vld;
    logic [2:0]       res_policy;
    logic [ID_W-1:0]  res_id;
    logic             init_done;
    logic [191:0]     stats;

    quota_table_ctrl #(.NUM_IDS(4), .ID_W(ID_W), .CNT_W(CNT_W), .LEN_W(LEN_W),
                       .HOST_STARVE_MAX(4)) dut (
        .asclk(asclk), .areset(areset),
        .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_id(pkt_id), .pkt_len(pkt_len),
        .pkt_ul(pkt_ul), .pkt_en(pkt_en), .pkt_mask(pkt_mask),
        .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_wr(cfg_wr), .cfg_id(cfg_id),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
        .cfg_rvld(cfg_rvld), .cfg_rdata(cfg_rdata),
        .res_vld(res_vld), .res_policy(res_policy), .res_id(res_id),
        .init_done(init_done), .stats(stats)
    );

    always #5 asclk = ~asclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge asclk) cyc <= cyc + 1;

    typedef struct { logic [2:0] pol; logic [ID_W-1:0] id; logic [LEN_W-1:0] len; int cyc; } res_exp_t;
    typedef struct { logic [CNT_W-1:0] data; int cyc; } cfg_exp_t;
    res_exp_t res_q[$];
    cfg_exp_t cfg_q[$];
    res_exp_t re;
    cfg_exp_t ce;
    logic [31:0] sb_fwd_b = 0, sb_sth_b = 0, sb_drop_b = 0, sb_fwd_c = 0, sb_sth_c = 0, sb_drop_c = 0;

    // Response monitor: every result/read pulse must match the oldest expectation
    always @(negedge asclk) begin
        if (res_vld) begin
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL res_unexpected got id=%0d pol=%0d required no result", res_id, res_policy);
            end else begin
                re = res_q.pop_front();
                if (res_policy !== re.pol || res_id !== re.id || cyc != re.cyc) begin
                    errors++;
                    $display("FAIL res got pol=%0d id=%0d cyc=%0d required pol=%0d id=%0d cyc=%0d",
                             res_policy, res_id, cyc, re.pol, re.id, re.cyc);
                end
                case (re.pol)
                    POL_DROP: begin sb_drop_c++; sb_drop_b += 32'(re.len); end
                    POL_STH:  begin sb_sth_c++;  sb_sth_b  += 32'(re.len); end
                    default:  begin sb_fwd_c++;  sb_fwd_b  += 32'(re.len); end
                endcase
            end
        end
        if (cfg_rvld) begin
            checks++;
            if (cfg_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got data=%0d required no read", cfg_rdata);
            end else begin
                ce = cfg_q.pop_front();
                if (cfg_rdata !== ce.data || cyc != ce.cyc) begin
                    errors++;
                    $display("FAIL rd got data=%0d cyc=%0d required data=%0d cyc=%0d",
                             cfg_rdata, cyc, ce.data, ce.cyc);
                end
            end
        end
    end

    task automatic send_pkt(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                            input logic ul, input logic en, input logic [5:0] mask,
                            input logic [2:0] exp_pol, input bit track);
        int n;
        n = 0;
        pkt_vld = 1'b1; pkt_id = id; pkt_len = len; pkt_ul = ul; pkt_en = en; pkt_mask = mask;
        @(negedge asclk);
        while (!pkt_rdy && n < 50) begin n++; @(negedge asclk); end
        if (!pkt_rdy) begin
            checks++; errors++;
            $display("FAIL pkt_handshake id=%0d rdy=%0b required 1", id, pkt_rdy);
        end else if (track) begin
            res_q.push_back('{exp_pol, id, len, cyc + 2});
        end
        @(posedge asclk); #1;
        pkt_vld = 1'b0;
    endtask

    task automatic send_cfg(input logic wr, input logic [ID_W-1:0] id, input logic [2:0] field,
                            input logic [CNT_W-1:0] data);
        int n;
        n = 0;
        cfg_vld = 1'b1; cfg_wr = wr; cfg_id = id; cfg_field = field; cfg_wdata = wr ? data : '0;
        @(negedge asclk);
        while (!cfg_rdy && n < 50) begin n++; @(negedge asclk); end
        if (!cfg_rdy) begin
            checks++; errors++;
            $display("FAIL cfg_handshake id=%0d rdy=%0b required 1", id, cfg_rdy);
        end else if (!wr) begin
            cfg_q.push_back('{data, cyc + 2});
        end
        @(posedge asclk); #1;
        cfg_vld = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge asclk);
        #1;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!init_done && n < 20) begin @(posedge asclk); #1; n++; end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_timeout init_done=%0b required 1", init_done);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge asclk);
        #1;
        checks++;
        if ({pkt_rdy, cfg_rdy, res_vld, cfg_rvld, init_done} !== 5'b0 || res_policy !== 3'd0 ||
            res_id !== '0 || cfg_rdata !== '0 || stats !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b%0b vld=%0b%0b init=%0b required all 0",
                     pkt_rdy, cfg_rdy, res_vld, cfg_rvld, init_done);
        end
        areset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge asclk); #1;
            checks++;
            if (init_done !== (i == 4) || pkt_rdy !== (i == 4) || cfg_rdy !== (i == 4)) begin
                errors++;
                $display("FAIL init_seq cycle=%0d got init=%0b rdy=%0b%0b required %0b",
                         i, init_done, pkt_rdy, cfg_rdy, (i == 4));
            end
        end
    endtask

    task automatic test_debit();
        send_pkt(0, 1000, 1'b1, 1'b1, 6'b000011, POL_FWD, 1'b1);
        send_cfg(1'b0, 0, FLD_QTOT, 48'd101400);
        send_cfg(1'b0, 0, FLD_QUL,  48'd70680);
        send_cfg(1'b0, 0, FLD_QDL,  48'd30720);
        send_cfg(1'b0, 0, FLD_TTOT, 48'd81920);
        // downlink packet with every counter enabled: uplink counters untouched
        send_pkt(3, 100, 1'b0, 1'b1, 6'b111111, POL_FWD, 1'b1);
        send_cfg(1'b0, 3, FLD_QTOT, 48'd102300);
        send_cfg(1'b0, 3, FLD_QUL,  48'd71680);
        send_cfg(1'b0, 3, FLD_QDL,  48'd30620);
        send_cfg(1'b0, 3, FLD_TUL,  48'd51200);
        send_cfg(1'b0, 3, FLD_TDL,  48'd30620);
        // counting disabled: forward, nothing debited
        send_pkt(3, 100, 1'b0, 1'b0, 6'b111111, POL_FWD, 1'b1);
        send_cfg(1'b0, 3, FLD_QTOT, 48'd102300);
        drain();
    endtask

    task automatic test_quota_exceed();
        send_cfg(1'b1, 1, FLD_QTOT, 48'd500);
        send_pkt(1, 600, 1'b1, 1'b1, 6'b000001, POL_DROP, 1'b1);
        send_cfg(1'b0, 1, FLD_QTOT, 48'd0);
        send_cfg(1'b1, 1, FLD_QTOT, 48'd500);
        send_pkt(1, 500, 1'b1, 1'b1, 6'b000001, POL_FWD, 1'b1);
        send_cfg(1'b0, 1, FLD_QTOT, 48'd0);
        // quota_flag[3]=1 turns a quota exceed into send-to-host
        send_cfg(1'b1, 3, FLD_QFLAG, 48'd8);
        send_cfg(1'b1, 3, FLD_QTOT, 48'd10);
        send_pkt(3, 20, 1'b0, 1'b1, 6'b000001, POL_STH, 1'b1);
        send_cfg(1'b0, 3, FLD_QFLAG, 48'd8);
        drain();
    endtask

    task automatic test_thres_and_flags();
        send_cfg(1'b1, 2, FLD_TTOT, 48'd100);
        send_pkt(2, 200, 1'b1, 1'b1, 6'b001000, POL_STH, 1'b1);
        send_cfg(1'b0, 2, FLD_TTOT, 48'd0);
        send_cfg(1'b0, 2, FLD_QFLAG, 48'd3);
        send_cfg(1'b0, 2, FLD_TFLAG, 48'd11);
        // quota drop (1) and threshold send-to-host (2) together resolve to drop
        send_cfg(1'b1, 2, FLD_QTOT, 48'd0);
        send_pkt(2, 1, 1'b1, 1'b1, 6'b001001, POL_DROP, 1'b1);
        // out-of-range accesses: write ignored, read returns 0
        send_cfg(1'b1, 9, FLD_QTOT, 48'd777);
        send_cfg(1'b0, 1, FLD_QTOT, 48'd0);
        send_cfg(1'b0, 9, FLD_QTOT, 48'd0);
        drain();
    endtask

    task automatic test_starve();
        bit exp_p;
        pkt_vld = 1'b1; pkt_id = 0; pkt_len = 7; pkt_ul = 1'b0; pkt_en = 1'b0; pkt_mask = 6'h3f;
        cfg_vld = 1'b1; cfg_wr = 1'b0; cfg_id = 0; cfg_field = FLD_QFLAG; cfg_wdata = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge asclk);
            exp_p = ((i % 5) != 4);
            checks++;
            if (pkt_rdy !== exp_p || cfg_rdy !== !exp_p) begin
                errors++;
                $display("FAIL starve_grant slot=%0d got pkt=%0b cfg=%0b required pkt=%0b cfg=%0b",
                         i, pkt_rdy, cfg_rdy, exp_p, !exp_p);
            end
            if (pkt_rdy) res_q.push_back('{POL_FWD, 14'd0, 16'd7, cyc + 2});
            if (cfg_rdy) cfg_q.push_back('{48'd3, cyc + 2});
        end
        @(posedge asclk); #1;
        pkt_vld = 1'b0; cfg_vld = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        send_cfg(1'b1, 0, FLD_QTOT, 48'd102400);
        send_pkt(0, 40000, 1'b1, 1'b1, 6'b000001, POL_FWD, 1'b1);
        send_cfg(1'b0, 0, FLD_QTOT, 48'd62400);
        send_pkt(0, 40000, 1'b1, 1'b1, 6'b000001, POL_FWD, 1'b1);
        send_cfg(1'b0, 0, FLD_QTOT, 48'd22400);
        send_pkt(0, 40000, 1'b1, 1'b1, 6'b000001, POL_DROP, 1'b1);
        send_cfg(1'b0, 0, FLD_QTOT, 48'd0);
        send_pkt(9, 5, 1'b1, 1'b1, 6'b111111, POL_FWD, 1'b1);
        send_cfg(1'b0, 1, FLD_QUL, 48'd71680);
        drain();
    endtask

    task automatic test_stats();
        logic [191:0] exp_stats;
        repeat (2) @(posedge asclk);
        #1;
`ifdef QUOTA_STATS_EN
        exp_stats = {sb_fwd_b, sb_sth_b, sb_drop_b, sb_fwd_c, sb_sth_c, sb_drop_c};
`else
        exp_stats = '0;
`endif
        checks++;
        if (stats !== exp_stats) begin
            errors++;
            $display("FAIL stats got %h required %h", stats, exp_stats);
        end
    endtask

    task automatic test_reset_mid();
        send_pkt(0, 1, 1'b1, 1'b1, 6'b000001, POL_DROP, 1'b1);
        send_pkt(0, 1, 1'b1, 1'b1, 6'b000001, POL_DROP, 1'b0);
        areset = 1'b1;
        repeat (2) @(posedge asclk);
        #1;
        checks++;
        if (res_vld !== 1'b0 || init_done !== 1'b0 || pkt_rdy !== 1'b0 || cfg_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got res_vld=%0b init=%0b rdy=%0b%0b required 0",
                     res_vld, init_done, pkt_rdy, cfg_rdy);
        end
        areset = 1'b0;
        wait_init();
        send_cfg(1'b0, 0, FLD_QTOT, 48'd102400);
        send_cfg(1'b0, 1, FLD_QTOT, 48'd102400);
        send_cfg(1'b0, 2, FLD_TTOT, 48'd81920);
        send_cfg(1'b0, 3, FLD_QFLAG, 48'd3);
        send_cfg(1'b0, 3, FLD_TFLAG, 48'd11);
        drain();
    endtask

    initial begin
        test_reset();
        test_debit();
        test_quota_exceed();
        test_thres_and_flags();
        test_starve();
        test_back_to_back();
        test_stats();
        test_reset_mid();
        repeat (4) @(posedge asclk);
        #1;
        checks++;
        if (res_q.size() != 0 || cfg_q.size() != 0) begin
            errors++;
            $display("FAIL pending got res=%0d rd=%0d required 0 0", res_q.size(), cfg_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
